bitstream_output_buffer: RTL and testbench

// Sink for the carry-propagation stage (stage 4). Accepts bursts of 0-4 resolved bytes per

---
 rtl/ob_pkg.sv | 35 +++
 rtl/ob_burst_decoder.sv | 29 ++
 rtl/bitstream_output_buffer.sv | 167 ++++++++++++++++
 tb/tb_bitstream_output_buffer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ob_pkg.sv
// ob_pkg: shared definitions for the bitstream output buffer, the carry-propagation
// stage that feeds it and the benches that exercise it.
//   - ob_flag_e        : burst flag encoding produced by the carry stage
//   - OB_FLAG_W        : width of the burst flag
//   - OB_MAX_BURST     : largest number of bytes in one burst
//   - ob_flag_to_count : flag -> number of bytes carried (0..4, 0 for illegal codes)
package ob_pkg;

   localparam int OB_FLAG_W    = 3;
   localparam int OB_MAX_BURST = 4;

   // The 2-byte and 3-byte codes are deliberately swapped relative to their byte count;
   // this matches the encoding the carry stage emits.
   typedef enum logic [OB_FLAG_W-1:0] {
      OB_FLAG_NONE = 3'd0,
      OB_FLAG_1B   = 3'd1,
      OB_FLAG_3B   = 3'd2,
      OB_FLAG_2B   = 3'd3,
      OB_FLAG_4B   = 3'd4
   } ob_flag_e;

   function automatic logic [2:0] ob_flag_to_count(input logic [OB_FLAG_W-1:0] flag);
      logic [2:0] cnt;
      case (flag)
         OB_FLAG_NONE: cnt = 3'd0;
         OB_FLAG_1B:   cnt = 3'd1;
         OB_FLAG_2B:   cnt = 3'd2;
         OB_FLAG_3B:   cnt = 3'd3;
         OB_FLAG_4B:   cnt = 3'd4;
         default:      cnt = 3'd0;
      endcase
      return cnt;
   endfunction

endpackage

// File: rtl/ob_burst_decoder.sv
// ob_burst_decoder: combinational decode of the carry-stage burst flag.
//   flag    in  3  burst flag (ob_flag_e encoding)
//   n       out 3  number of bytes in the burst (0..4)
//   lane_en out 4  per-lane write enable, lane 0 = oldest byte
//   illegal out 1  flag is one of the unused codes 5..7
module ob_burst_decoder
   import ob_pkg::*;
(
   input  logic [OB_FLAG_W-1:0]    flag,
   output logic [2:0]              n,
   output logic [OB_MAX_BURST-1:0] lane_en,
   output logic                    illegal
);

   // Byte count, thermometer lane enables and illegal-code detection.
   always_comb begin
      n       = ob_flag_to_count(flag);
      illegal = (flag > OB_FLAG_4B);
      case (n)
         3'd0:    lane_en = 4'b0000;
         3'd1:    lane_en = 4'b0001;
         3'd2:    lane_en = 4'b0011;
         3'd3:    lane_en = 4'b0111;
         3'd4:    lane_en = 4'b1111;
         default: lane_en = 4'b0000;
      endcase
   end

endmodule

// File: rtl/bitstream_output_buffer.sv
// bitstream_output_buffer: circular byte buffer between the carry-propagation stage and
// the bitstream writer. Accepts 0..4 bytes per cycle, drains one byte per cycle over a
// first-word-fall-through valid/ready port, in arrival order.
//   ob_clk, ob_reset           clock (rising edge), asynchronous active-high reset
//   in_carry_bit_1..3,
//   in_carry_last_bit          burst bytes, oldest first
//   in_carry_flag              burst flag (ob_flag_e)
//   in_flag_last               burst closes the frame (tags its final byte)
//   in_carry_error             upstream error indication
//   out_byte/out_valid/out_ready  head-of-buffer byte and handshake
//   out_last                   head byte is the final byte of a frame
//   out_frame_done             one-cycle pulse after the final frame byte is popped
//   out_almost_full            free entries below the stall margin
//   out_level                  number of stored bytes
//   out_overflow, out_error    sticky status, cleared only by reset
module bitstream_output_buffer
   import ob_pkg::*;
#(
   parameter int OB_BITSTREAM_WIDTH = 8,
   parameter int OB_DEPTH_LOG2      = 4,
   parameter int OB_AF_MARGIN       = 4
)
(
   input  logic                          ob_clk,
   input  logic                          ob_reset,
   input  logic [OB_BITSTREAM_WIDTH-1:0] in_carry_bit_1,
   input  logic [OB_BITSTREAM_WIDTH-1:0] in_carry_bit_2,
   input  logic [OB_BITSTREAM_WIDTH-1:0] in_carry_bit_3,
   input  logic [OB_BITSTREAM_WIDTH-1:0] in_carry_last_bit,
   input  logic [OB_FLAG_W-1:0]          in_carry_flag,
   input  logic                          in_flag_last,
   input  logic                          in_carry_error,
   output logic [OB_BITSTREAM_WIDTH-1:0] out_byte,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_last,
   output logic                          out_frame_done,
   output logic                          out_almost_full,
   output logic [OB_DEPTH_LOG2:0]        out_level,
   output logic                          out_overflow,
   output logic                          out_error
);

   localparam int                   DEPTH   = 2 ** OB_DEPTH_LOG2;
   localparam logic [OB_DEPTH_LOG2:0] DEPTH_C = (OB_DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [OB_DEPTH_LOG2:0] AF_C    = (OB_DEPTH_LOG2 + 1)'(OB_AF_MARGIN);

   logic [OB_BITSTREAM_WIDTH-1:0] mem_r [DEPTH];
   logic [DEPTH-1:0]              tag_r;
   logic [OB_DEPTH_LOG2-1:0]      wr_ptr_r;
   logic [OB_DEPTH_LOG2-1:0]      rd_ptr_r;
   logic [OB_DEPTH_LOG2:0]        count_r;
   logic                          overflow_r;
   logic                          error_r;
   logic                          frame_done_r;

   logic [2:0]                    n_s;
   logic [OB_MAX_BURST-1:0]       lane_en_s;
   logic                          illegal_s;
   logic [OB_BITSTREAM_WIDTH-1:0] lane_data_s [OB_MAX_BURST];
   logic [OB_DEPTH_LOG2:0]        n_ext_s;
   logic [OB_DEPTH_LOG2:0]        free_s;
   logic [OB_DEPTH_LOG2:0]        add_s;
   logic                          accept_s;
   logic                          drop_s;
   logic                          pop_s;
   logic                          err_event_s;

   ob_burst_decoder u_decoder (
      .flag    (in_carry_flag),
      .n       (n_s),
      .lane_en (lane_en_s),
      .illegal (illegal_s)
   );

   // Accept/drop decision and error detection for the incoming burst.
   always_comb begin
      lane_data_s[0] = in_carry_bit_1;
      lane_data_s[1] = in_carry_bit_2;
      lane_data_s[2] = in_carry_bit_3;
      lane_data_s[3] = in_carry_last_bit;
      n_ext_s        = {{(OB_DEPTH_LOG2 - 2){1'b0}}, n_s};
      // Space is judged on the count before this cycle's pop, so a full buffer
      // never accepts even if a byte leaves in the same cycle.
      free_s         = DEPTH_C - count_r;
      pop_s          = out_valid & out_ready;
      if (n_s != 3'd0) begin
         accept_s = (n_ext_s <= free_s);
         drop_s   = (n_ext_s > free_s);
      end else begin
         accept_s = 1'b0;
         drop_s   = 1'b0;
      end
      if (accept_s) begin
         add_s = n_ext_s;
      end else begin
         add_s = {(OB_DEPTH_LOG2 + 1){1'b0}};
      end
      // A last marker on an empty burst has nowhere to go and is reported as an error.
      err_event_s = in_carry_error | illegal_s |
                    (in_flag_last & (in_carry_flag == OB_FLAG_NONE));
   end

   // Byte storage; deliberately not reset, validity is tracked by count/pointers.
   always_ff @(posedge ob_clk) begin
      for (int k = 0; k < OB_MAX_BURST; k++) begin
         if (accept_s && lane_en_s[k]) begin
            mem_r[wr_ptr_r + k[OB_DEPTH_LOG2-1:0]] <= lane_data_s[k];
         end
      end
   end

   // Pointers, count, frame tags and status registers.
   always_ff @(posedge ob_clk or posedge ob_reset) begin
      if (ob_reset) begin
         wr_ptr_r     <= {OB_DEPTH_LOG2{1'b0}};
         rd_ptr_r     <= {OB_DEPTH_LOG2{1'b0}};
         count_r      <= {(OB_DEPTH_LOG2 + 1){1'b0}};
         tag_r        <= {DEPTH{1'b0}};
         overflow_r   <= 1'b0;
         error_r      <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         if (pop_s) begin
            tag_r[rd_ptr_r] <= 1'b0;
            rd_ptr_r        <= rd_ptr_r + {{(OB_DEPTH_LOG2 - 1){1'b0}}, 1'b1};
         end
         // Written entries never coincide with the popped one (accept needs free space),
         // so these tag writes cannot collide with the clear above.
         for (int k = 0; k < OB_MAX_BURST; k++) begin
            if (accept_s && lane_en_s[k]) begin
               tag_r[wr_ptr_r + k[OB_DEPTH_LOG2-1:0]] <= in_flag_last & (3'(k) == (n_s - 3'd1));
            end
         end
         if (accept_s) begin
            wr_ptr_r <= wr_ptr_r + n_ext_s[OB_DEPTH_LOG2-1:0];
         end
         count_r      <= count_r + add_s - {{OB_DEPTH_LOG2{1'b0}}, pop_s};
         frame_done_r <= pop_s & out_last;
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
         if (err_event_s) begin
            error_r <= 1'b1;
         end
      end
   end

   // Output view of the registered state (first-word fall-through).
   always_comb begin
      out_valid = (count_r != {(OB_DEPTH_LOG2 + 1){1'b0}});
      if (out_valid) begin
         out_byte = mem_r[rd_ptr_r];
         out_last = tag_r[rd_ptr_r];
      end else begin
         // Storage is not reset, so hide stale bytes while the buffer is empty.
         out_byte = {OB_BITSTREAM_WIDTH{1'b0}};
         out_last = 1'b0;
      end
      out_almost_full = (free_s < AF_C);
      out_level       = count_r;
      out_overflow    = overflow_r;
      out_error       = error_r;
      out_frame_done  = frame_done_r;
   end

endmodule

// File: tb/tb_bitstream_output_buffer.sv
// tb_bitstream_output_buffer: directed and randomized bench for bitstream_output_buffer.
// A queue of {last, byte} entries models the buffer; status bits are modelled directly
// from their definitions.
module tb_bitstream_output_buffer;
   import ob_pkg::*;

   logic       ob_clk = 1'b0;
   logic       ob_reset = 1'b0;
   logic [7:0] in_carry_bit_1 = 8'd0;
   logic [7:0] in_carry_bit_2 = 8'd0;
   logic [7:0] in_carry_bit_3 = 8'd0;
   logic [7:0] in_carry_last_bit = 8'd0;
   logic [2:0] in_carry_flag = 3'd0;
   logic       in_flag_last = 1'b0;
   logic       in_carry_error = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] out_byte;
   logic       out_valid;
   logic       out_last;
   logic       out_frame_done;
   logic       out_almost_full;
   logic [4:0] out_level;
   logic       out_overflow;
   logic       out_error;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [8:0] mq[$];
   logic       m_fd;
   logic       m_ovf;
   logic       m_err;

   bitstream_output_buffer dut (
      .ob_clk            (ob_clk),
      .ob_reset          (ob_reset),
      .in_carry_bit_1    (in_carry_bit_1),
      .in_carry_bit_2    (in_carry_bit_2),
      .in_carry_bit_3    (in_carry_bit_3),
      .in_carry_last_bit (in_carry_last_bit),
      .in_carry_flag     (in_carry_flag),
      .in_flag_last      (in_flag_last),
      .in_carry_error    (in_carry_error),
      .out_byte          (out_byte),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_last          (out_last),
      .out_frame_done    (out_frame_done),
      .out_almost_full   (out_almost_full),
      .out_level         (out_level),
      .out_overflow      (out_overflow),
      .out_error         (out_error)
   );

   always #5 ob_clk = ~ob_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bytes carried by each flag code, straight from the flag table.
   function automatic int nbytes(input logic [2:0] f);
      case (f)
         3'd1:    return 1;
         3'd3:    return 2;
         3'd2:    return 3;
         3'd4:    return 4;
         default: return 0;
      endcase
   endfunction

   task automatic check_outputs();
      int sz;
      sz = mq.size();
      chk("valid", 32'(out_valid), 32'(sz != 0));
      if (sz != 0) begin
         chk("byte", 32'(out_byte), 32'(mq[0][7:0]));
         chk("last", 32'(out_last), 32'(mq[0][8]));
      end else begin
         chk("last", 32'(out_last), 32'd0);
      end
      chk("frame_done", 32'(out_frame_done), 32'(m_fd));
      chk("almost_full", 32'(out_almost_full), 32'((16 - sz) < 4));
      chk("level", 32'(out_level), 32'(sz));
      chk("overflow", 32'(out_overflow), 32'(m_ovf));
      chk("error", 32'(out_error), 32'(m_err));
   endtask

   // Check current outputs, then advance DUT and model by one clock.
   task automatic step();
      int         sz;
      int         n;
      logic       pop;
      logic       fd_n;
      logic       acc;
      logic [7:0] lanes [4];
      check_outputs();
      sz    = mq.size();
      n     = nbytes(in_carry_flag);
      pop   = (sz != 0) && out_ready;
      fd_n  = pop && mq[0][8];
      acc   = (n != 0) && (n <= 16 - sz);
      lanes = '{in_carry_bit_1, in_carry_bit_2, in_carry_bit_3, in_carry_last_bit};
      if (n != 0 && !acc) m_ovf = 1'b1;
      if (in_carry_error || in_carry_flag > 3'd4 || (in_flag_last && in_carry_flag == 3'd0))
         m_err = 1'b1;
      @(posedge ob_clk);
      if (pop) void'(mq.pop_front());
      if (acc) begin
         for (int k = 0; k < n; k++) mq.push_back({in_flag_last && (k == n - 1), lanes[k]});
      end
      m_fd = fd_n;
      @(negedge ob_clk);
   endtask

   task automatic drive(input logic [2:0] f, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4, input logic lst,
                        input logic rdy);
      in_carry_flag     = f;
      in_carry_bit_1    = b1;
      in_carry_bit_2    = b2;
      in_carry_bit_3    = b3;
      in_carry_last_bit = b4;
      in_flag_last      = lst;
      out_ready         = rdy;
   endtask

   task automatic idle(input logic rdy);
      drive(3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, rdy);
   endtask

   // Asynchronous reset mid-cycle: outputs must drop immediately.
   task automatic do_reset();
      ob_reset = 1'b1;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_byte", 32'(out_byte), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_fd", 32'(out_frame_done), 32'd0);
      chk("rst_af", 32'(out_almost_full), 32'd0);
      chk("rst_level", 32'(out_level), 32'd0);
      chk("rst_ovf", 32'(out_overflow), 32'd0);
      chk("rst_err", 32'(out_error), 32'd0);
      mq.delete();
      m_fd  = 1'b0;
      m_ovf = 1'b0;
      m_err = 1'b0;
      @(negedge ob_clk);
      ob_reset = 1'b0;
   endtask

   initial begin
      logic [2:0] f;
      #1;
      do_reset();

      // single byte into empty buffer with ready high: no pop in the write cycle
      drive(3'd1, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      step();
      chk("single_byte", 32'(out_byte), 32'hA5);
      chk("single_level", 32'(out_level), 32'd1);
      idle(1'b1);
      step();

      // four-byte burst drains in order
      drive(3'd4, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b1);
      step();
      idle(1'b1);
      repeat (5) step();

      // wrap: fill 10, drain 8, add 8 more past the end of the array
      for (int i = 0; i < 5; i++) begin
         drive(3'd3, 8'(8'h50 + 2 * i), 8'(8'h51 + 2 * i), 8'h00, 8'h00, 1'b0, 1'b0);
         step();
      end
      chk("wrap_level10", 32'(out_level), 32'd10);
      idle(1'b1);
      repeat (8) step();
      drive(3'd4, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 1'b0, 1'b0);
      step();
      drive(3'd4, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 1'b0, 1'b0);
      step();
      chk("wrap_level10b", 32'(out_level), 32'd10);
      idle(1'b1);
      repeat (11) step();

      // frame tag on the third byte of a 3-byte burst
      drive(3'd2, 8'h01, 8'h02, 8'h03, 8'h00, 1'b1, 1'b0);
      step();
      idle(1'b1);
      repeat (3) step();
      chk("frame_done_pulse", 32'(out_frame_done), 32'd1);
      step();

      // overflow: fill to 14 then offer a 4-byte burst
      for (int i = 0; i < 3; i++) begin
         drive(3'd4, 8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3), 1'b0, 1'b0);
         step();
      end
      drive(3'd3, 8'hE0, 8'hE1, 8'h00, 8'h00, 1'b0, 1'b0);
      step();
      chk("ovf_level14", 32'(out_level), 32'd14);
      drive(3'd4, 8'hF0, 8'hF1, 8'hF2, 8'hF3, 1'b0, 1'b1);
      step();
      chk("ovf_level_kept", 32'(out_level), 32'd13);
      chk("ovf_sticky", 32'(out_overflow), 32'd1);
      chk("ovf_af", 32'(out_almost_full), 32'd1);
      idle(1'b1);
      repeat (14) step();

      // illegal flag: nothing written, error set
      drive(3'd6, 8'h99, 8'h99, 8'h99, 8'h99, 1'b0, 1'b1);
      step();
      chk("illegal_err", 32'(out_error), 32'd1);
      chk("illegal_level", 32'(out_level), 32'd0);

      // reset with data in flight
      drive(3'd4, 8'h71, 8'h72, 8'h73, 8'h74, 1'b0, 1'b0);
      step();
      do_reset();

      // orphan last marker
      drive(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
      step();
      idle(1'b0);
      chk("orphan_err", 32'(out_error), 32'd1);
      step();
      do_reset();

      // upstream error input
      in_carry_error = 1'b1;
      step();
      in_carry_error = 1'b0;
      chk("carry_err", 32'(out_error), 32'd1);
      step();
      do_reset();

      // randomized traffic from a well-behaved upstream model
      for (int i = 0; i < 4000; i++) begin
         if ((16 - mq.size()) < 4) begin
            f = 3'd0;
         end else begin
            case ($urandom_range(0, 4))
               0:       f = 3'd0;
               1:       f = 3'd1;
               2:       f = 3'd2;
               3:       f = 3'd3;
               default: f = 3'd4;
            endcase
         end
         drive(f, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               (f != 3'd0) && ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 70 : 35)));
         step();
      end
      idle(1'b1);
      repeat (20) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
